top_level_module: RTL and testbench
===================================

TOP_LEVEL_MODULE -- requirements
Module: top_level_module

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 instruction  input  16  [15:13] opcode, [12:0] operand.
REQ-004 valid  input  1  qualifies a_in1/a_in2 as array data this cycle.
REQ-005 a_in1  input  16  unsigned activation into array row 1.
REQ-006 a_in2  input  16  unsigned activation into array row 2, fed one cycle behind row 1.
REQ-007 acc1_mem_0, acc1_mem_1  output  32 each  column-1 accumulator entries 0/1.
REQ-008 acc2_mem_0, acc2_mem_1  output  32 each  column-2 accumulator entries 0/1.
REQ-009 unified_mem_0..unified_mem_3  output  32 each  unified buffer words 0..3.

Function
REQ-010 Opcodes SHALL be: 000 NOP, 001 LOAD_ADDR, 010 LOAD_WEIGHT; 011-111 behave as NOP.
REQ-011 LOAD_ADDR SHALL register operand[4:0] as base_addr at the clock edge.
REQ-012 Weight memory SHALL be 32 x 16 bits, reset contents all zero except addr 15=1, 16=2, 17=3, 18=4; not writable through the port set.
REQ-013 LOAD_WEIGHT SHALL, in one edge, load W11=mem[base], W12=mem[base+1], W21=mem[base+2], W22=mem[base+3] (addresses mod 32) into the four PEs; repeating the opcode reloads the same weights, with no effect on in-flight psums.
REQ-014 Array SHALL be 2x2 weight-stationary: PE(r,c) registers a_out<=a_in and psum_out<=psum_in + a_in*W_rc each cycle; a flows right along a row, psum flows down a column, top-row psum_in=0.
REQ-015 Products SHALL be 16x16 unsigned to 32 bits; sums SHALL wrap modulo 2^32.
REQ-016 When valid=0 the PE inputs a_in1/a_in2 SHALL be forced to 0.
REQ-017 Let t0 be the first cycle valid=1 after reset; column-1 result (PE21 psum) SHALL be captured into acc1 entries 0,1 at the edges ending t0+2, t0+3; column-2 (PE22 psum) into acc2 entries 0,1 at edges ending t0+3, t0+4.
REQ-018 Each accumulator write pointer SHALL saturate at 2; later results are discarded until reset.
REQ-019 Unified buffer SHALL copy acc1_mem_0, acc1_mem_1, acc2_mem_0, acc2_mem_1 into words 0..3 one cycle after each accumulator write.
REQ-020 Resulting math: with vectors x_k=(a_in1@t0+k, a_in2@t0+k+1), k=0,1: entry k of column j = x_k1*W1j + x_k2*W2j.

Reset
REQ-021 On reset SHALL clear base_addr, all PE weights/a/psum registers, accumulator entries and pointers, unified buffer, t0 tracking; restore weight memory contents; all outputs read 0 the cycle after reset.
REQ-022 Reset asserted mid-stream SHALL abort the computation; the next valid rise defines a new t0.

Structure
REQ-023 A shared package SHALL hold opcode constants, data/acc widths (16/32), weight-memory depth (32), and array size (2).
REQ-024 One sub-module processing_element SHALL implement REQ-014/015 and be instantiated four times.

Verification
REQ-025 Reset; LOAD_ADDR 0x000F; LOAD_WEIGHT; valid=1 with a_in1=11,12,0..., a_in2=0,21,22,0... -> acc1=74,78; acc2=106,112; unified_mem_0..3=74,78,106,112 after 7 cycles.
REQ-026 Same stream with base_addr 0 (weights all zero) -> all accumulator and unified outputs 0.
REQ-027 Continue valid=1 with nonzero data for 10 more cycles after REQ-025 -> outputs unchanged (saturation).
REQ-028 Assert reset at t0+2 of the REQ-025 stream -> all outputs 0 next cycle; rerun stream -> REQ-025 values.
REQ-029 Opcode 111 and NOP between LOAD_ADDR and LOAD_WEIGHT -> base_addr and weights unaffected, REQ-025 results.
REQ-030 LOAD_ADDR 0x001E (wrap): weights mem[30],mem[31],mem[0],mem[1] all 0 -> results 0.

Source files
------------

// File: rtl/top_level_module_pkg.sv
// Shared constants for the 2x2 weight-stationary array: opcodes, widths, weight ROM image.
package top_level_module_pkg;

  localparam int DATA_W     = 16;
  localparam int ACC_W      = 32;
  localparam int WMEM_DEPTH = 32;
  localparam int ADDR_W     = 5;
  localparam int ARRAY_N    = 2;

  localparam logic [2:0] OP_NOP         = 3'b000;
  localparam logic [2:0] OP_LOAD_ADDR   = 3'b001;
  localparam logic [2:0] OP_LOAD_WEIGHT = 3'b010;

  // Power-up / reset image of the weight memory.
  function automatic logic [DATA_W-1:0] weight_rom(input logic [ADDR_W-1:0] addr);
    case (addr)
      5'd15:   return 16'd1;
      5'd16:   return 16'd2;
      5'd17:   return 16'd3;
      5'd18:   return 16'd4;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/top_level_module_pe.sv
// Weight-stationary MAC cell: registers a_in and psum_in + a_in*weight every cycle.
// Latency 1 cycle for both a and psum; free-running, no backpressure.
module processing_element
  import top_level_module_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_w,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [ACC_W-1:0]  psum_in,
  output logic [DATA_W-1:0] a_out,
  output logic [ACC_W-1:0]  psum_out
);

  logic [DATA_W-1:0] weight;
  logic [ACC_W-1:0]  prod;

  assign prod = ACC_W'(a_in) * ACC_W'(weight);

  always_ff @(posedge clk) begin
    if (reset) begin
      weight   <= '0;
      a_out    <= '0;
      psum_out <= '0;
    end else begin
      if (load_w) weight <= w_in;
      a_out    <= a_in;
      psum_out <= psum_in + prod;
    end
  end

endmodule

// File: rtl/top_level_module.sv
// 2x2 systolic matrix-vector engine with weight ROM, two-entry accumulators and unified buffer.
// Results land t0+2..t0+4, buffer one cycle later; free-running, no backpressure.
module top_level_module
  import top_level_module_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic        valid,
  input  logic [15:0] a_in1,
  input  logic [15:0] a_in2,
  output logic [31:0] acc1_mem_0,
  output logic [31:0] acc1_mem_1,
  output logic [31:0] acc2_mem_0,
  output logic [31:0] acc2_mem_1,
  output logic [31:0] unified_mem_0,
  output logic [31:0] unified_mem_1,
  output logic [31:0] unified_mem_2,
  output logic [31:0] unified_mem_3
);

  logic [2:0]        opcode;
  logic [ADDR_W-1:0] base_addr;
  logic [DATA_W-1:0] wmem [WMEM_DEPTH];
  logic              load_w;
  logic [DATA_W-1:0] a_row1, a_row2;
  logic [DATA_W-1:0] a11_out, a12_out, a21_out, a22_out;
  logic [ACC_W-1:0]  p11_out, p12_out, p21_out, p22_out;

  logic              started;
  logic [2:0]        cyc;
  logic [1:0]        ptr1, ptr2;
  logic [ACC_W-1:0]  acc1 [ARRAY_N];
  logic [ACC_W-1:0]  acc2 [ARRAY_N];
  logic [ACC_W-1:0]  unified [2*ARRAY_N];
  logic              unused_bits;

  assign opcode = instruction[15:13];
  assign load_w = (opcode == OP_LOAD_WEIGHT);
  assign a_row1 = valid ? a_in1 : '0;
  assign a_row2 = valid ? a_in2 : '0;
  assign unused_bits = ^{instruction[12:5], a12_out, a22_out};

  // Weight memory has no write port; reset restores the ROM image.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WMEM_DEPTH; i++) wmem[i] <= weight_rom(ADDR_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                       base_addr <= '0;
    else if (opcode == OP_LOAD_ADDR) base_addr <= instruction[ADDR_W-1:0];
  end

  processing_element pe11 (.clk(clk), .reset(reset), .load_w(load_w), .w_in(wmem[base_addr]),
                           .a_in(a_row1), .psum_in('0), .a_out(a11_out), .psum_out(p11_out));
  processing_element pe12 (.clk(clk), .reset(reset), .load_w(load_w), .w_in(wmem[base_addr + 5'd1]),
                           .a_in(a11_out), .psum_in('0), .a_out(a12_out), .psum_out(p12_out));
  processing_element pe21 (.clk(clk), .reset(reset), .load_w(load_w), .w_in(wmem[base_addr + 5'd2]),
                           .a_in(a_row2), .psum_in(p11_out), .a_out(a21_out), .psum_out(p21_out));
  processing_element pe22 (.clk(clk), .reset(reset), .load_w(load_w), .w_in(wmem[base_addr + 5'd3]),
                           .a_in(a21_out), .psum_in(p12_out), .a_out(a22_out), .psum_out(p22_out));

  // cyc holds k during cycle t0+k; column 1 drains from k=2, column 2 one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      started <= 1'b0;
      cyc     <= '0;
      ptr1    <= '0;
      ptr2    <= '0;
      for (int i = 0; i < ARRAY_N; i++) begin
        acc1[i] <= '0;
        acc2[i] <= '0;
      end
      for (int i = 0; i < 2*ARRAY_N; i++) unified[i] <= '0;
    end else begin
      if (!started && valid) begin
        started <= 1'b1;
        cyc     <= 3'd1;
      end else if (started && cyc != 3'd7) begin
        cyc <= cyc + 3'd1;
      end
      if (started && cyc >= 3'd2 && ptr1 < 2'd2) begin
        acc1[ptr1[0]] <= p21_out;
        ptr1          <= ptr1 + 2'd1;
      end
      if (started && cyc >= 3'd3 && ptr2 < 2'd2) begin
        acc2[ptr2[0]] <= p22_out;
        ptr2          <= ptr2 + 2'd1;
      end
      unified[0] <= acc1[0];
      unified[1] <= acc1[1];
      unified[2] <= acc2[0];
      unified[3] <= acc2[1];
    end
  end

  assign acc1_mem_0    = acc1[0];
  assign acc1_mem_1    = acc1[1];
  assign acc2_mem_0    = acc2[0];
  assign acc2_mem_1    = acc2[1];
  assign unified_mem_0 = unified[0];
  assign unified_mem_1 = unified[1];
  assign unified_mem_2 = unified[2];
  assign unified_mem_3 = unified[3];

endmodule

// File: tb/tb_top_level_module.sv
// Randomized bench for top_level_module against a matrix-vector reference model.
module tb_top_level_module;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic        valid;
  logic [15:0] a_in1, a_in2;
  logic [31:0] acc1_mem_0, acc1_mem_1, acc2_mem_0, acc2_mem_1;
  logic [31:0] unified_mem_0, unified_mem_1, unified_mem_2, unified_mem_3;

  int checks = 0;
  int errors = 0;

  logic [15:0] s_a1 [16];
  logic [15:0] s_a2 [16];
  logic        s_v  [16];
  logic [31:0] e_c1 [2];
  logic [31:0] e_c2 [2];

  always #5 clk = ~clk;

  top_level_module dut (
    .clk(clk), .reset(reset), .instruction(instruction), .valid(valid),
    .a_in1(a_in1), .a_in2(a_in2),
    .acc1_mem_0(acc1_mem_0), .acc1_mem_1(acc1_mem_1),
    .acc2_mem_0(acc2_mem_0), .acc2_mem_1(acc2_mem_1),
    .unified_mem_0(unified_mem_0), .unified_mem_1(unified_mem_1),
    .unified_mem_2(unified_mem_2), .unified_mem_3(unified_mem_3)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] wref(input int addr);
    int a;
    a = addr % 32;
    if (a >= 15 && a <= 18) return 16'(a - 14);
    return 16'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; valid = 1'b0; instruction = '0; a_in1 = '0; a_in2 = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic load_directed();
    for (int i = 0; i < 16; i++) begin
      s_v[i] = 1'b1; s_a1[i] = '0; s_a2[i] = '0;
    end
    s_a1[0] = 16'd11; s_a1[1] = 16'd12;
    s_a2[1] = 16'd21; s_a2[2] = 16'd22;
  endtask

  task automatic test_reset();
    logic [31:0] got [8];
    do_reset();
    got = '{acc1_mem_0, acc1_mem_1, acc2_mem_0, acc2_mem_1,
            unified_mem_0, unified_mem_1, unified_mem_2, unified_mem_3};
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (got[j] !== 32'd0) begin
        errors++;
        $display("FAIL reset out%0d got %0d want 0", j, got[j]);
      end
    end
  endtask

  // Resets, programs base address and weights, streams s_* and checks every cycle.
  task automatic run_stream(input string name, input logic [12:0] operand, input bit extra_ops,
                            input int reset_at, input bit reload_mid);
    int base, t0, rel, r;
    logic [15:0] w11, w12, w21, w22, xa, xb;
    logic [31:0] got [8];
    logic [31:0] exp [8];
    base = int'(operand[4:0]);
    w11 = wref(base); w12 = wref(base + 1); w21 = wref(base + 2); w22 = wref(base + 3);
    t0 = -1;
    for (int i = 15; i >= 0; i--) if (s_v[i]) t0 = i;
    for (int k = 0; k < 2; k++) begin
      xa = (t0 >= 0 && t0 + k < 16     && s_v[t0 + k])     ? s_a1[t0 + k]     : 16'd0;
      xb = (t0 >= 0 && t0 + k + 1 < 16 && s_v[t0 + k + 1]) ? s_a2[t0 + k + 1] : 16'd0;
      e_c1[k] = 32'(xa) * 32'(w11) + 32'(xb) * 32'(w21);
      e_c2[k] = 32'(xa) * 32'(w12) + 32'(xb) * 32'(w22);
    end

    do_reset();
    instruction = {3'b001, operand}; step();
    if (extra_ops) begin
      instruction = {3'b111, 13'($urandom)}; step();
      instruction = 16'd0; step();
    end
    instruction = {3'b010, 13'($urandom)}; step();
    instruction = 16'd0;

    for (int i = 0; i < 16; i++) begin
      valid = s_v[i]; a_in1 = s_a1[i]; a_in2 = s_a2[i];
      r = $urandom_range(0, 6);
      instruction = reload_mid ? {3'(r + ((r >= 1) ? 1 : 0)), 13'($urandom)} : 16'd0;
      reset = (t0 >= 0 && reset_at >= 0 && i == t0 + reset_at);
      step();
      got = '{acc1_mem_0, acc1_mem_1, acc2_mem_0, acc2_mem_1,
              unified_mem_0, unified_mem_1, unified_mem_2, unified_mem_3};
      rel = (t0 >= 0 && i >= t0) ? i - t0 : -1;
      exp[0] = (rel >= 2) ? e_c1[0] : 32'd0;
      exp[1] = (rel >= 3) ? e_c1[1] : 32'd0;
      exp[2] = (rel >= 3) ? e_c2[0] : 32'd0;
      exp[3] = (rel >= 4) ? e_c2[1] : 32'd0;
      exp[4] = (rel >= 3) ? e_c1[0] : 32'd0;
      exp[5] = (rel >= 4) ? e_c1[1] : 32'd0;
      exp[6] = (rel >= 4) ? e_c2[0] : 32'd0;
      exp[7] = (rel >= 5) ? e_c2[1] : 32'd0;
      if (reset) for (int j = 0; j < 8; j++) exp[j] = 32'd0;
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (got[j] !== exp[j]) begin
          errors++;
          $display("FAIL %s cyc %0d out%0d got %0d want %0d", name, i, j, got[j], exp[j]);
        end
      end
      if (reset) begin
        reset = 1'b0;
        break;
      end
    end
    valid = 1'b0; instruction = 16'd0; reset = 1'b0;
  endtask

  task automatic test_directed();
    load_directed();
    run_stream("directed", 13'h000F, 1'b0, -1, 1'b0);
  endtask

  task automatic test_saturation();
    logic [31:0] got [8];
    logic [31:0] exp [8];
    exp = '{e_c1[0], e_c1[1], e_c2[0], e_c2[1], e_c1[0], e_c1[1], e_c2[0], e_c2[1]};
    for (int c = 0; c < 10; c++) begin
      valid = 1'b1;
      a_in1 = 16'($urandom_range(1, 65535));
      a_in2 = 16'($urandom_range(1, 65535));
      step();
      got = '{acc1_mem_0, acc1_mem_1, acc2_mem_0, acc2_mem_1,
              unified_mem_0, unified_mem_1, unified_mem_2, unified_mem_3};
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (got[j] !== exp[j]) begin
          errors++;
          $display("FAIL saturation cyc %0d out%0d got %0d want %0d", c, j, got[j], exp[j]);
        end
      end
    end
    valid = 1'b0;
  endtask

  task automatic test_zero_weights();
    load_directed();
    run_stream("zero_w", 13'h0000, 1'b0, -1, 1'b0);
  endtask

  task automatic test_mid_reset();
    load_directed();
    run_stream("mid_reset", 13'h000F, 1'b0, 2, 1'b0);
    load_directed();
    run_stream("after_reset", 13'h000F, 1'b0, -1, 1'b0);
  endtask

  task automatic test_ignored_ops();
    load_directed();
    run_stream("ignored_ops", 13'h000F, 1'b1, -1, 1'b0);
  endtask

  task automatic test_wrap();
    load_directed();
    run_stream("wrap", 13'h001E, 1'b0, -1, 1'b0);
  endtask

  task automatic test_random();
    int lead;
    for (int it = 0; it < 8; it++) begin
      lead = $urandom_range(0, 4);
      for (int i = 0; i < 16; i++) begin
        s_v[i]  = (i < lead) ? 1'b0 : ((i == lead) ? 1'b1 : ($urandom_range(0, 3) != 0));
        s_a1[i] = 16'($urandom);
        s_a2[i] = 16'($urandom);
      end
      run_stream("random", {8'($urandom), 5'($urandom_range(12, 19))},
                 1'($urandom_range(0, 1)), -1, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; instruction = '0; a_in1 = '0; a_in2 = '0;
    test_reset();
    test_directed();
    test_saturation();
    test_zero_weights();
    test_mid_reset();
    test_ignored_ops();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
